// File: rtl/spirw_master.sv
// spirw_master
// SPI master for the OSD byte-oriented read/write protocol. A frame is a
// command byte (0x00 write / 0x01 read), a 32-bit big-endian address
// {16'h0000, i_addr}, one dummy byte for reads, then i_len data bytes.
// SPI mode 0, MSB first.
//
// Parameters:
//   c_clk_div : SCLK half-period in clk cycles (2..255)
//   c_gap     : minimum clk cycles csn stays high between frames (>=1)
// Ports:
//   clk, resetn                  : clock, asynchronous active-low reset
//   i_start, i_rd, i_addr, i_len : request, sampled when o_busy=0
//   i_wr_data, i_wr_valid        : write byte stream
//   o_wr_ready                   : write byte consumed this cycle
//   o_rd_data, o_rd_valid        : received data byte and its strobe
//   o_busy, o_done               : transfer status
//   o_csn, o_sclk, o_mosi, i_miso: SPI pins
module spirw_master #(
  parameter int c_clk_div = 2,
  parameter int c_gap     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_len,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_csn,
  output logic        o_sclk,
  output logic        o_mosi,
  input  logic        i_miso
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_HOLD, S_GAP
  } state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_cnt;      // divider / setup / hold / gap counter
  logic [2:0]  r_bit;      // bit index 7 -> 0 within a byte
  logic        r_sclk;
  logic [7:0]  r_shift;    // TX shift register, MSB drives mosi
  logic [6:0]  r_rx;       // RX shift register (8th bit taken straight from miso)
  logic [7:0]  r_rd_data;
  logic        r_rd_valid;
  logic        r_done;
  logic        r_rd;
  logic [15:0] r_addr;
  logic [16:0] r_total;    // header + dummy + data bytes in this frame
  logic [16:0] r_idx;      // index of the byte currently loaded/shifting

  logic        w_cnt_last;
  logic        w_is_data;
  logic        w_wr_take;
  logic        w_load_go;
  logic        w_byte_end;
  logic        w_last_byte;
  logic [7:0]  w_tx_byte;

  // The shared counter terminates at c_gap in GAP, at c_clk_div elsewhere.
  assign w_cnt_last  = (r_state == S_GAP) ? (r_cnt == 16'(c_gap - 1))
                                          : (r_cnt == 16'(c_clk_div - 1));
  assign w_is_data   = r_idx >= (r_rd ? 17'd6 : 17'd5);
  assign w_wr_take   = (r_state == S_LOAD) && w_is_data && !r_rd && i_wr_valid;
  // Only write data bytes can stall in LOAD.
  assign w_load_go   = !w_is_data || r_rd || i_wr_valid;
  // Last half-period of bit 0 ends on the 8th falling edge.
  assign w_byte_end  = (r_state == S_SHIFT) && w_cnt_last && r_sclk && (r_bit == 3'd0);
  assign w_last_byte = (r_idx + 17'd1) == r_total;

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_idx)
      17'd0:   w_tx_byte = {7'b0, r_rd};
      17'd3:   w_tx_byte = r_addr[15:8];
      17'd4:   w_tx_byte = r_addr[7:0];
      default: w_tx_byte = (w_is_data && !r_rd) ? i_wr_data : 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start)    w_state_next = S_SETUP;
      S_SETUP: if (w_cnt_last) w_state_next = S_LOAD;
      S_LOAD:  if (w_load_go)  w_state_next = S_SHIFT;
      S_SHIFT: if (w_byte_end) w_state_next = w_last_byte ? S_HOLD : S_LOAD;
      S_HOLD:  if (w_cnt_last) w_state_next = S_GAP;
      S_GAP:   if (w_cnt_last) w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_csn      = 1'b1;
    o_mosi     = 1'b0;
    case (r_state)
      S_SETUP, S_LOAD, S_HOLD: o_csn = 1'b0;
      S_SHIFT: begin
        o_csn  = 1'b0;
        o_mosi = r_shift[7];
      end
      default: ;
    endcase
    o_busy     = (r_state != S_IDLE);
    o_wr_ready = w_wr_take;
  end

  assign o_sclk     = r_sclk;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_done     = r_done;

  // Datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_bit      <= 3'd7;
      r_sclk     <= 1'b0;
      r_shift    <= '0;
      r_rx       <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_rd       <= 1'b0;
      r_addr     <= '0;
      r_total    <= '0;
      r_idx      <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_start) begin
            r_rd    <= i_rd;
            r_addr  <= i_addr;
            r_total <= 17'd5 + {16'b0, i_rd} + {1'b0, i_len};
            r_idx   <= '0;
          end
        end
        S_SETUP, S_GAP: r_cnt <= w_cnt_last ? '0 : r_cnt + 16'd1;
        S_HOLD: begin
          r_cnt  <= w_cnt_last ? '0 : r_cnt + 16'd1;
          r_done <= w_cnt_last;  // visible the first cycle csn is high
        end
        S_LOAD: begin
          if (w_load_go) begin
            r_shift <= w_tx_byte;
            r_cnt   <= '0;
            r_bit   <= 3'd7;
            r_sclk  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_cnt_last) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              // Rising edge: sample miso.
              r_rx <= {r_rx[5:0], i_miso};
              if (r_bit == 3'd0 && r_rd && w_is_data) begin
                r_rd_data  <= {r_rx, i_miso};
                r_rd_valid <= 1'b1;
              end
            end else begin
              // Falling edge: advance mosi and the bit counter.
              r_shift <= {r_shift[6:0], 1'b0};
              r_bit   <= r_bit - 3'd1;
              if (r_bit == 3'd0) r_idx <= r_idx + 17'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
